// File: rtl/hv_bundle_stream.sv
// Hypervector bundler: per-bit saturating vote counters, sign snapshot on fin, streamed out as DIM/OUT_W beats.
// Optional `HV_SAT_DETECT_EN adds sat_flag, reporting counter clamping in the bundle currently being streamed.
module hv_bundle_stream #(
  parameter int DIM   = 1024,
  parameter int NCORE = 4,
  parameter int CW    = 30,
  parameter int OUT_W = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORE-1:0]       store,
  input  logic [NCORE*DIM-1:0]   core_result,
  input  logic                   fin,
  input  logic                   tmp_even,
  input  logic [DIM-1:0]         tmp_rand,
  input  logic                   stream_ready,
  output logic [OUT_W-1:0]       stream_d,
  output logic                   stream_v,
  output logic                   stream_last,
  output logic                   busy,
  output logic                   ovf_err
`ifdef HV_SAT_DETECT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int NB = DIM / OUT_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(NCORE + 1) + 2;

  localparam logic signed [CW:0]   SAT_MAX = {2'b00, {(CW-1){1'b1}}};
  localparam logic signed [CW:0]   SAT_MIN = -SAT_MAX;
  localparam logic signed [SW-1:0] VOTE_UP = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] VOTE_DN = {SW{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SNAP  = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic signed [CW-1:0]  cnt_q [DIM];
  logic signed [CW-1:0]  cnt_d [DIM];
  logic [DIM-1:0]        sign_q, sign_d;
  logic [DIM-1:0]        snap_vec;
  logic [BW-1:0]         beat_q, beat_d, beat_nx;
  logic [OUT_W-1:0]      stream_d_q, stream_d_d;
  logic                  stream_v_q, stream_v_d;
  logic                  stream_last_q, stream_last_d;
  logic                  ovf_q, ovf_d;
  logic                  tie_en;
  logic                  clamp_any;
  logic signed [SW-1:0]  vote;
  logic signed [CW:0]    base_w, vote_w, sum_w;

  // The tie-break only joins the vote when fin is actually accepted.
  assign tie_en = fin & tmp_even & (state_q == ST_ACCUM);

  // Per-bit vote: sum of +/-1 over storing cores, widened and added to the
  // counter with symmetric saturation. SNAP restarts from zero so the stores
  // arriving on that cycle already belong to the next bundle.
  always_comb begin
    clamp_any = 1'b0;
    vote      = '0;
    base_w    = '0;
    vote_w    = '0;
    sum_w     = '0;
    for (int i = 0; i < DIM; i++) begin
      vote = '0;
      for (int k = 0; k < NCORE; k++) begin
        if (store[k]) vote = vote + (core_result[k*DIM + i] ? VOTE_UP : VOTE_DN);
      end
      if (tie_en) vote = vote + (tmp_rand[i] ? VOTE_UP : VOTE_DN);
      vote_w = (CW+1)'(vote);
      base_w = (CW+1)'(cnt_q[i]);
      if (state_q == ST_SNAP) base_w = '0;
      sum_w = base_w + vote_w;
      if (sum_w > SAT_MAX) begin
        cnt_d[i]  = SAT_MAX[CW-1:0];
        clamp_any = 1'b1;
      end else if (sum_w < SAT_MIN) begin
        cnt_d[i]  = SAT_MIN[CW-1:0];
        clamp_any = 1'b1;
      end else begin
        cnt_d[i]  = sum_w[CW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      snap_vec[i] = !cnt_q[i][CW-1] && (cnt_q[i] != '0);
    end
  end

  assign beat_nx = beat_q + BW'(1);

  // Output beats are registered; SNAP preloads beat 0 straight from the
  // counters so the first beat appears one cycle after the snapshot.
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    beat_d        = beat_q;
    stream_d_d    = stream_d_q;
    stream_v_d    = stream_v_q;
    stream_last_d = stream_last_q;
    ovf_d         = ovf_q | (fin & (state_q != ST_ACCUM));
    case (state_q)
      ST_ACCUM: begin
        if (fin) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        sign_d        = snap_vec;
        beat_d        = '0;
        stream_d_d    = snap_vec[OUT_W-1:0];
        stream_v_d    = 1'b1;
        stream_last_d = (NB == 1);
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (stream_v_q && stream_ready) begin
          if (beat_q == BW'(NB - 1)) begin
            beat_d        = '0;
            stream_d_d    = '0;
            stream_v_d    = 1'b0;
            stream_last_d = 1'b0;
            state_d       = ST_ACCUM;
          end else begin
            beat_d        = beat_nx;
            stream_d_d    = sign_q[int'(beat_nx) * OUT_W +: OUT_W];
            stream_last_d = (beat_nx == BW'(NB - 1));
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_ACCUM;
      cnt_q         <= '{default: '0};
      sign_q        <= '0;
      beat_q        <= '0;
      stream_d_q    <= '0;
      stream_v_q    <= 1'b0;
      stream_last_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      beat_q        <= beat_d;
      stream_d_q    <= stream_d_d;
      stream_v_q    <= stream_v_d;
      stream_last_q <= stream_last_d;
      ovf_q         <= ovf_d;
    end
  end

`ifdef HV_SAT_DETECT_EN
  logic sat_acc_q, sat_acc_d;
  logic sat_flag_q, sat_flag_d;

  // sat_acc collects clamps for the bundle being built; on SNAP it is handed
  // to sat_flag alongside the sign snapshot and restarts with SNAP's own clamps.
  always_comb begin
    sat_acc_d  = sat_acc_q | clamp_any;
    sat_flag_d = sat_flag_q;
    if (state_q == ST_SNAP) begin
      sat_flag_d = sat_acc_q;
      sat_acc_d  = clamp_any;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_acc_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_acc_q  <= sat_acc_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign stream_d    = stream_d_q;
  assign stream_v    = stream_v_q;
  assign stream_last = stream_last_q;
  assign busy        = (state_q != ST_ACCUM);
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_hv_bundle_stream.sv
// Bench for hv_bundle_stream: a transaction-level vote model plus a per-cycle
// output compare, pinned by hand-computed bundle words.
module tb_hv_bundle_stream;

  localparam int DIM   = 8;
  localparam int NCORE = 4;
  localparam int CW    = 4;
  localparam int OUT_W = 4;
  localparam int NB    = DIM / OUT_W;
  localparam int SMAX  = 2 ** (CW - 1) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCORE-1:0]     store;
  logic [NCORE*DIM-1:0] core_result;
  logic                 fin;
  logic                 tmp_even;
  logic [DIM-1:0]       tmp_rand;
  logic                 stream_ready;
  logic [OUT_W-1:0]     stream_d;
  logic                 stream_v;
  logic                 stream_last;
  logic                 busy;
  logic                 ovf_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: signed vote totals per bit, queue of bundles awaiting output.
  int             acc [DIM];
  int             mc  [DIM];
  logic [DIM-1:0] q[$];
  logic [DIM-1:0] exp_log[$];
  logic [DIM-1:0] dut_log[$];
  logic [DIM-1:0] got_word = '0;
  logic [DIM-1:0] cur;
  logic [DIM-1:0] vec;
  bit             mdl_busy  = 0;
  bit             snap_next = 0;
  bit             exp_ovf   = 0;
  bit             hs_flag   = 0;
  bit             exp_v;
  int             mdl_beat  = 0;
  int             exp_rd    = 0;
  int             dut_rd    = 0;

  always #5 clk = ~clk;

  hv_bundle_stream #(
    .DIM(DIM), .NCORE(NCORE), .CW(CW), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .store(store),
    .core_result(core_result),
    .fin(fin),
    .tmp_even(tmp_even),
    .tmp_rand(tmp_rand),
    .stream_ready(stream_ready),
    .stream_d(stream_d),
    .stream_v(stream_v),
    .stream_last(stream_last),
    .busy(busy),
    .ovf_err(ovf_err)
  );

  function automatic int sat(input int x);
    if (x > SMAX) return SMAX;
    if (x < -SMAX) return -SMAX;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCORE-1:0] st, input logic [NCORE*DIM-1:0] cr,
                               input logic f, input logic ev, input logic [DIM-1:0] rnd,
                               input logic rdy);
    store        = st;
    core_result  = cr;
    fin          = f;
    tmp_even     = ev;
    tmp_rand     = rnd;
    stream_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((q.size() != 0 || mdl_busy) && n < budget) begin
      applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    if (q.size() != 0 || mdl_busy) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout: bundle still pending after %0d cycles", budget);
    end
  endtask

  task automatic checkWord(input string name, input logic [DIM-1:0] lit);
    if (exp_rd >= exp_log.size()) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s_model: no bundle produced, expected 0x%0h", name, lit);
    end else begin
      checkOutput({name, "_model"}, 32'(exp_log[exp_rd]), 32'(lit));
      exp_rd++;
    end
    if (dut_rd >= dut_log.size()) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s_dut: no bundle streamed, expected 0x%0h", name, lit);
    end else begin
      checkOutput({name, "_dut"}, 32'(dut_log[dut_rd]), 32'(lit));
      dut_rd++;
    end
  endtask

  // Model: fin is accepted only when no bundle is pending; the cycle after an
  // accepted fin takes the snapshot and restarts the votes from that cycle's stores.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      for (int i = 0; i < DIM; i++) acc[i] = 0;
      q.delete();
      mdl_busy = 0; snap_next = 0; exp_ovf = 0; mdl_beat = 0;
    end else begin
      for (int i = 0; i < DIM; i++) begin
        mc[i] = 0;
        for (int k = 0; k < NCORE; k++)
          if (store[k]) mc[i] += core_result[k*DIM + i] ? 1 : -1;
      end
      if (snap_next) begin
        for (int i = 0; i < DIM; i++) begin
          vec[i] = (acc[i] > 0);
          acc[i] = sat(mc[i]);
        end
        q.push_back(vec);
        exp_log.push_back(vec);
        snap_next = 0;
      end else begin
        for (int i = 0; i < DIM; i++) begin
          if (fin && !mdl_busy && tmp_even) mc[i] += tmp_rand[i] ? 1 : -1;
          acc[i] = sat(acc[i] + mc[i]);
        end
      end
      if (fin) begin
        if (mdl_busy) exp_ovf = 1;
        else begin
          mdl_busy  = 1;
          snap_next = 1;
        end
      end
      if (hs_flag) begin
        if (mdl_beat == NB - 1) begin
          void'(q.pop_front());
          mdl_beat = 0;
          mdl_busy = 0;
        end else begin
          mdl_beat++;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus capture of streamed words.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      hs_flag = 0;
    end else begin
      exp_v = (q.size() != 0);
      checkOutput("stream_v", 32'(stream_v), 32'(exp_v));
      if (exp_v) begin
        cur = q[0];
        checkOutput("stream_d", 32'(stream_d), 32'(cur[mdl_beat*OUT_W +: OUT_W]));
        checkOutput("stream_last", 32'(stream_last), 32'(mdl_beat == NB - 1));
      end
      checkOutput("busy", 32'(busy), 32'(mdl_busy));
      checkOutput("ovf_err", 32'(ovf_err), 32'(exp_ovf));
      if (stream_v && stream_ready) begin
        got_word[mdl_beat*OUT_W +: OUT_W] = stream_d;
        if (mdl_beat == NB - 1) dut_log.push_back(got_word);
      end
      hs_flag = exp_v && stream_ready;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    store = '0; core_result = '0; fin = 1'b0; tmp_even = 1'b0; tmp_rand = '0; stream_ready = 1'b1;
    #12;
    checkOutput("rst_v", 32'(stream_v), 32'd0);
    checkOutput("rst_d", 32'(stream_d), 32'd0);
    checkOutput("rst_last", 32'(stream_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] majority");
    applyStimulus(4'hF, {4{8'hF0}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, {4{8'hF0}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, {4{8'h0F}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("majority", 8'hF0);

    $display("[TB] tie-break");
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b1, 8'hA5, 1'b1);
    waitIdle(20);
    checkWord("tie_on", 8'hA5);
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'hA5, 1'b1);
    waitIdle(20);
    checkWord("tie_off", 8'h00);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("zero_vec", 8'h00);

    $display("[TB] backpressure");
    applyStimulus(4'b0001, {24'h0, 8'h3C}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("bp_hold_v", 32'(stream_v), 32'd1);
      checkOutput("bp_hold_d", 32'(stream_d), 32'hC);
    end
    waitIdle(20);
    checkWord("backpressure", 8'h3C);

    $display("[TB] saturation");
    for (int c = 0; c < 10; c++) applyStimulus(4'hF, {4{8'hFF}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("sat_ones", 8'hFF);
    for (int c = 0; c < 10; c++) applyStimulus(4'hF, {4{8'hF0}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, {4{8'h0F}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'hF, {4{8'h0F}}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("sat_clamp", 8'h0F);

    $display("[TB] overlap and overrun");
    applyStimulus(4'b0001, {24'h0, 8'h5A}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'b0001, {24'h0, 8'hF0}, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'b0010, {16'h0, 8'h0F, 8'h00}, 1'b1, 1'b1, 8'hFF, 1'b0);
    applyStimulus(4'b0100, {8'h00, 8'h3C, 16'h0}, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_set", 32'(ovf_err), 32'd1);
    waitIdle(20);
    checkWord("overlap_a", 8'h5A);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("overlap_b", 8'h3C);
    checkOutput("no_extra", 32'(dut_log.size() - dut_rd), 32'd0);

    $display("[TB] async reset mid-send");
    applyStimulus(4'b0001, {24'h0, 8'h96}, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_v", 32'(stream_v), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_v", 32'(stream_v), 32'd0);
    checkOutput("arst_d", 32'(stream_d), 32'd0);
    checkOutput("arst_last", 32'(stream_last), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_ovf", 32'(ovf_err), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_rd = exp_log.size();
    dut_rd = dut_log.size();
    @(posedge clk); #1;

    applyStimulus(4'hF, {8'h96, 8'h69, 8'h96, 8'h96}, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("last_beat", 32'(stream_last), 32'd1);
    applyStimulus(4'h0, '0, 1'b1, 1'b0, 8'h00, 1'b1);
    waitIdle(20);
    checkWord("post_reset", 8'h96);
    checkOutput("late_fin_ovf", 32'(ovf_err), 32'd1);
    for (int c = 0; c < 4; c++) applyStimulus(4'h0, '0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("late_fin_no_bundle", 32'(dut_log.size() - dut_rd), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
